// File: rtl/fir_pkg.sv
// Shared types and defaults for the fir datapath and its tap feeder.
package fir_pkg;

  localparam int DWIDTH = 15;
  localparam int NTAPS  = 37;
  localparam int CWIDTH = 16;  // coefficient width used by fir

  typedef enum logic [1:0] {
    S_FILL  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2
  } feeder_state_t;

  typedef logic [DWIDTH-1:0] win_t [NTAPS];

  // Width needed to hold a count from 0 to n inclusive.
  function automatic int cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/fir_tap_feeder_if.sv
// Upstream sample handshake into the tap feeder, plus the flush request.
interface fir_tap_feeder_if #(
  parameter int DWIDTH = fir_pkg::DWIDTH
);

  logic              s_valid;
  logic              s_ready;
  logic [DWIDTH-1:0] s_data;
  logic              flush;

  modport master (output s_valid, output s_data, output flush, input s_ready);
  modport slave  (input s_valid, input s_data, input flush, output s_ready);

endinterface

// File: rtl/fir_decim_ctr.sv
// Decimation phase counter: one EN pulse for every DECIM eligible shifts.
module fir_decim_ctr #(
  parameter int DECIM = 1
) (
  input  logic CLK,
  input  logic RST,
  input  logic eligible,
  input  logic clear,
  output logic en
);

  localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;

  logic [PW-1:0] phase;

  // Down-counter: EN fires on the terminal count, then reloads DECIM-1.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      phase <= '0;
      en    <= 1'b0;
    end else begin
      en <= eligible && (phase == PW'(0));
      if (clear) begin
        phase <= '0;
      end else if (eligible) begin
        if (phase == PW'(0)) phase <= PW'(DECIM - 1);
        else                 phase <= phase - PW'(1);
      end
    end
  end

endmodule

// File: rtl/fir_tap_feeder.sv
// Serial-to-window tap feeder for the parallel fir: delay line, prime gating,
// decimated EN generation and a zero flush of the filter tail.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_FILL  | accepting samples, window not yet holding NTAPS real samples
// S_RUN   | window full of real samples, one sample per cycle sustained
// S_FLUSH | shifting NTAPS zeros through the window, upstream stalled
module fir_tap_feeder #(
  parameter int DWIDTH     = fir_pkg::DWIDTH,
  parameter int NTAPS      = fir_pkg::NTAPS,
  parameter int DECIM      = 1,
  parameter int PRIME_GATE = 1
) (
  input  logic              CLK,
  input  logic              RST,
  fir_tap_feeder_if.slave   up,
  output logic [DWIDTH-1:0] din_win [NTAPS],
  output logic              EN,
  output logic              primed,
  output logic              flushing
);

  import fir_pkg::*;

  localparam int CW = cnt_w(NTAPS);

  feeder_state_t state, state_nxt;
  logic [CW-1:0] fill_cnt, fill_nxt;
  logic [CW-1:0] flush_cnt, flush_cnt_nxt;
  logic          smp_shift;
  logic          fl_shift;
  logic          last_flush;
  logic          eligible;

  // Ready is a function of state only; held low while in reset.
  assign up.s_ready = RST && (state != S_FLUSH);
  assign flushing   = (state == S_FLUSH);

  always_comb begin
    state_nxt     = state;
    fill_nxt      = fill_cnt;
    flush_cnt_nxt = flush_cnt;
    smp_shift     = up.s_valid && up.s_ready;
    fl_shift      = (state == S_FLUSH);
    last_flush    = fl_shift && (flush_cnt == CW'(1));

    if (smp_shift && (fill_cnt != CW'(NTAPS))) fill_nxt = fill_cnt + CW'(1);

    case (state)
      S_FILL: begin
        if (up.flush) begin
          state_nxt     = S_FLUSH;
          flush_cnt_nxt = CW'(NTAPS);
        end else if (fill_nxt == CW'(NTAPS)) begin
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (up.flush) begin
          state_nxt     = S_FLUSH;
          flush_cnt_nxt = CW'(NTAPS);
        end
      end
      S_FLUSH: begin
        flush_cnt_nxt = flush_cnt - CW'(1);
        if (last_flush) begin
          state_nxt = S_FILL;
          fill_nxt  = '0;
        end
      end
      default: state_nxt = S_FILL;
    endcase

    if (PRIME_GATE != 0) eligible = fl_shift || (smp_shift && (fill_nxt == CW'(NTAPS)));
    else                 eligible = fl_shift || smp_shift;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= S_FILL;
      fill_cnt  <= '0;
      flush_cnt <= '0;
      primed    <= 1'b0;
    end else begin
      state     <= state_nxt;
      fill_cnt  <= fill_nxt;
      flush_cnt <= flush_cnt_nxt;
      primed    <= (fill_nxt == CW'(NTAPS));
    end
  end

  // Window and EN update on the same edge so fir sees them together.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < NTAPS; i++) din_win[i] <= '0;
    end else if (smp_shift || fl_shift) begin
      for (int i = 0; i < NTAPS - 1; i++) din_win[i] <= din_win[i+1];
      din_win[NTAPS-1] <= fl_shift ? '0 : up.s_data;
    end
  end

  fir_decim_ctr #(.DECIM(DECIM)) u_decim (
    .CLK      (CLK),
    .RST      (RST),
    .eligible (eligible),
    .clear    (last_flush),
    .en       (EN)
  );

endmodule

// File: tb/tb_fir_tap_feeder.sv
// Scoreboard bench: two feeders (DECIM=1 and DECIM=4) share one directed stimulus.
module tb_fir_tap_feeder;

  localparam int DW = 15;
  localparam int NT = 37;

  typedef struct {
    logic [DW-1:0] oldest;
    logic [DW-1:0] newest;
    int            nz;
    logic          primed;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic s_valid = 1'b0;
  logic flush = 1'b0;
  logic [DW-1:0] s_data = '0;

  logic [DW-1:0] win_a [NT];
  logic [DW-1:0] win_b [NT];
  logic en_a, en_b, primed_a, primed_b, flushing_a, flushing_b;

  exp_t q_a[$];
  exp_t q_b[$];
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fir_tap_feeder_if #(.DWIDTH(DW)) if_a ();
  fir_tap_feeder_if #(.DWIDTH(DW)) if_b ();

  assign if_a.s_valid = s_valid;
  assign if_a.s_data  = s_data;
  assign if_a.flush   = flush;
  assign if_b.s_valid = s_valid;
  assign if_b.s_data  = s_data;
  assign if_b.flush   = flush;

  fir_tap_feeder #(.DWIDTH(DW), .NTAPS(NT), .DECIM(1), .PRIME_GATE(1)) dut_a (
    .CLK(clk), .RST(rst_n), .up(if_a), .din_win(win_a),
    .EN(en_a), .primed(primed_a), .flushing(flushing_a)
  );

  fir_tap_feeder #(.DWIDTH(DW), .NTAPS(NT), .DECIM(4), .PRIME_GATE(1)) dut_b (
    .CLK(clk), .RST(rst_n), .up(if_b), .din_win(win_b),
    .EN(en_b), .primed(primed_b), .flushing(flushing_b)
  );

  function automatic int count_nz(input logic [DW-1:0] w [NT]);
    int n = 0;
    for (int i = 0; i < NT; i++) if (w[i] != '0) n++;
    return n;
  endfunction

  function automatic exp_t mk(input int o, input int n, input int z, input bit p);
    exp_t e;
    e.oldest = DW'(o);
    e.newest = DW'(n);
    e.nz     = z;
    e.primed = p;
    return e;
  endfunction

  task automatic chk(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: every EN pulse pops the next expected window snapshot.
  always @(negedge clk) begin
    exp_t e;
    if (en_a) begin
      if (q_a.size() == 0) chk("a_unexpected_en", 1, 0);
      else begin
        e = q_a.pop_front();
        chk("a_oldest", int'(win_a[0]), int'(e.oldest));
        chk("a_newest", int'(win_a[NT-1]), int'(e.newest));
        chk("a_nonzero_taps", count_nz(win_a), e.nz);
        chk("a_primed", int'(primed_a), int'(e.primed));
      end
    end
    if (en_b) begin
      if (q_b.size() == 0) chk("b_unexpected_en", 1, 0);
      else begin
        e = q_b.pop_front();
        chk("b_oldest", int'(win_b[0]), int'(e.oldest));
        chk("b_newest", int'(win_b[NT-1]), int'(e.newest));
        chk("b_nonzero_taps", count_nz(win_b), e.nz);
        chk("b_primed", int'(primed_b), int'(e.primed));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int v);
    s_valid = 1'b1;
    s_data  = DW'(v);
    tick();
  endtask

  task automatic drain(input string name);
    s_valid = 1'b0;
    flush   = 1'b0;
    repeat (3) tick();
    chk({name, "_a_missing_en"}, q_a.size(), 0);
    chk({name, "_b_missing_en"}, q_b.size(), 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    int cnt;

    // Reset state
    repeat (2) tick();
    chk("rst_win_nz", count_nz(win_a), 0);
    chk("rst_en", int'(en_a), 0);
    chk("rst_primed", int'(primed_a), 0);
    chk("rst_flushing", int'(flushing_a), 0);
    chk("rst_ready", int'(if_a.s_ready), 0);
    rst_n = 1'b1;
    tick();
    chk("post_rst_ready", int'(if_a.s_ready), 1);

    // Impulse: 36 zeros then a one
    for (int k = 1; k <= NT; k++) begin
      if (k == NT) begin
        q_a.push_back(mk(0, 1, 1, 1'b1));
        q_b.push_back(mk(0, 1, 1, 1'b1));
      end
      send((k == NT) ? 1 : 0);
    end
    drain("impulse");
    chk("impulse_primed_hold", int'(primed_a), 1);
    do_reset();

    // Decimation: samples 1..50 back to back
    for (int k = 1; k <= 50; k++) begin
      if (k >= NT) q_a.push_back(mk(k - 36, k, NT, 1'b1));
      if (k >= NT && ((k - NT) % 4) == 0) q_b.push_back(mk(k - 36, k, NT, 1'b1));
      send(k);
    end
    drain("decim");
    do_reset();

    // Gapped valid: 80 cycles, valid on even cycles only
    cnt = 0;
    for (int c = 0; c < 80; c++) begin
      if ((c % 2) == 0) begin
        cnt++;
        if (cnt >= NT) q_a.push_back(mk(cnt - 36, cnt, NT, 1'b1));
        if (cnt == NT) q_b.push_back(mk(cnt - 36, cnt, NT, 1'b1));
        send(cnt);
      end else begin
        s_valid = 1'b0;
        s_data  = '1;
        tick();
        chk("gap_window_hold", int'(win_a[NT-1]), cnt);
      end
    end
    drain("gapped");
    chk("gapped_shift_count", int'(win_a[NT-1]), 40);

    // Flush after samples 1..40: window 4..40 drains to zero
    for (int j = 1; j <= NT; j++) begin
      q_a.push_back(mk((j < NT) ? 4 + j : 0, 0, NT - j, j < NT));
      if ((j % 4) == 1) q_b.push_back(mk((j < NT) ? 4 + j : 0, 0, NT - j, j < NT));
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    for (int c = 1; c <= NT; c++) begin
      chk("flush_ready_low", int'(if_a.s_ready), 0);
      chk("flush_flushing", int'(flushing_a), 1);
      tick();
    end
    chk("flush_ready_back", int'(if_a.s_ready), 1);
    chk("flush_flushing_done", int'(flushing_a), 0);
    chk("flush_primed_clear", int'(primed_a), 0);
    chk("flush_win_zero", count_nz(win_a), 0);
    drain("flush");

    // Collision: sample 7 and flush on the same edge, flush retriggered mid-flush
    for (int j = 1; j <= NT; j++) begin
      q_a.push_back(mk((j == NT - 1) ? 7 : 0, 0, (j < NT) ? 1 : 0, 1'b0));
      if ((j % 4) == 1) q_b.push_back(mk((j == NT - 1) ? 7 : 0, 0, (j < NT) ? 1 : 0, 1'b0));
    end
    s_valid = 1'b1;
    s_data  = DW'(7);
    flush   = 1'b1;
    tick();
    s_valid = 1'b0;
    flush   = 1'b0;
    chk("collide_sample_first", int'(win_a[NT-1]), 7);
    chk("collide_flushing", int'(flushing_a), 1);
    for (int c = 1; c <= NT; c++) begin
      flush = (c == 10);
      tick();
    end
    flush = 1'b0;
    chk("collide_ready_back", int'(if_a.s_ready), 1);
    chk("collide_win_zero", count_nz(win_a), 0);
    tick();
    chk("collide_no_restart", int'(flushing_a), 0);
    drain("collide");

    // Reset mid-stream, then a fresh prime
    for (int k = 201; k <= 220; k++) send(k);
    s_valid = 1'b0;
    rst_n = 1'b0;
    #2;
    chk("midrst_win_nz", count_nz(win_a), 0);
    chk("midrst_en", int'(en_a), 0);
    chk("midrst_ready", int'(if_a.s_ready), 0);
    chk("midrst_primed", int'(primed_a), 0);
    tick();
    rst_n = 1'b1;
    tick();
    for (int k = 101; k <= 137; k++) begin
      if (k == 137) begin
        q_a.push_back(mk(101, 137, NT, 1'b1));
        q_b.push_back(mk(101, 137, NT, 1'b1));
      end
      send(k);
    end
    drain("reprime");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
